sseg_rot_ctrl: RTL and testbench
================================

Name: sseg_rot_ctrl

Overview:
- Upstream control stage for the rotating-square seven-segment display driver; produces that driver's `en` input.
- Debounces raw pushbuttons to toggle run/pause and cycle through four rotation speeds.
- Generates a gated enable strobe whose duty cycle sets how fast the display counter advances.
- Pure control block; no display outputs.

Parameters:
- DB_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button edge (10 ms at 100 MHz); must be ≥2.
- STEP_LEN, 33_554_432, en-high cycles per single step (2^25, i.e. one display position of a 28-bit driver counter); used only with SSEG_STEP_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- btn_run  input  1  raw pushbutton, asynchronous to clk; press toggles run/pause
- btn_speed  input  1  raw pushbutton, asynchronous; press advances speed 0→1→2→3→0
- btn_step  input  1  raw pushbutton, asynchronous; present only with SSEG_STEP_EN
- en  output  1  enable to display driver
- running  output  1  run state (status LED)
- speed  output  2  current speed level (status LEDs)

Behaviour:
- Reset (asynchronous, active-high; clock clk): running=0, speed=0, en=0, prescaler=0, all synchronisers=0, all debounce FSMs in IDLE, step counter=0. Reset mid-debounce or mid-step aborts it.
- Each button passes through a 2-flop synchroniser, then its own debounce FSM with a counter of width $clog2(DB_CYCLES).
- Debounce FSM states:
  - IDLE: on sync=1, clear counter and go to DB_HI.
  - DB_HI: sync=0 → IDLE. Counter==DB_CYCLES-1 → HELD and assert a 1-cycle press pulse. Otherwise increment.
  - HELD: on sync=0, clear counter and go to DB_LO.
  - DB_LO: sync=1 → HELD. Counter==DB_CYCLES-1 → IDLE. Otherwise increment.
- Press timing: exactly one pulse per accepted press. Holding a button never repeats. Glitches shorter than DB_CYCLES are ignored.
- Latency: when a raw input goes high at edge k and stays stable, the register update (running or speed) is visible after edge k+DB_CYCLES+3.
- Run press: running toggles; prescaler clears to 0.
- Speed press: speed = speed+1 mod 4 (3 wraps to 0); prescaler clears to 0; running is unchanged.
- Simultaneous run and speed presses in the same cycle: both applied; prescaler clears.
- Prescaler: 3-bit counter. It increments every cycle while running=1 (wraps 7→0) and holds while running=0.
- Enable generation:
  - mask = (1<<speed)-1.
  - en = running & ((prescaler & mask)==0), derived from registers only, so it is glitch-free.
  - en duty: speed0 every cycle, speed1 every 2nd cycle, speed2 every 4th, speed3 every 8th.
  - First en after resume or speed change occurs in the first cycle with running=1.
- running=0 → en=0, except during a step (see Optional Feature).

Optional Feature:
- Macro: SSEG_STEP_EN.
- Defined:
  - btn_step port exists, with its own synchroniser and debounce FSM.
  - Step press while running=0 and step counter==0: load step counter with STEP_LEN; en=1 while counter≠0; counter decrements each cycle. This gives exactly STEP_LEN en-high cycles, independent of speed.
  - Step press while running=1, or during an active step: ignored.
  - Run press during a step: step counter clears; running=1; normal prescaled en resumes.
  - Speed press during a step: speed updates; step continues unaffected.
- Undefined:
  - btn_step port and step logic are absent.
  - en depends only on running, speed and prescaler.

Test Plan (simulate with DB_CYCLES=4, STEP_LEN=8):
- Assert reset mid-operation → running=0, speed=0, en=0 immediately, with no clock edge needed; after release en stays 0 with no button activity.
- btn_run high for 10 cycles → running=1 exactly 7 cycles after the rising edge; en=1 every cycle; one toggle only despite the long hold.
- btn_run pulses of 2 and 3 cycles → running unchanged; no press accepted.
- Running; press btn_speed three times → speed 1, 2, 3; en period 2, 4, 8 cycles respectively; a fourth press → speed=0 and en continuous.
- btn_run and btn_speed pressed the same cycle from reset → running=1 and speed=1 at the same edge; en high on the first running cycle, then every 2nd cycle.
- SSEG_STEP_EN: paused, step press → en high exactly 8 consecutive cycles, then 0. A second step press mid-step is ignored. A run press mid-step → running=1 and prescaled en resumes.

Source files
------------

// File: rtl/sseg_rot_ctrl.sv
// Run/pause and speed control for the rotating-square display driver; drives its `en`.
// Optional single-step button and step logic enabled by defining SSEG_STEP_EN.

// Two-flop synchroniser plus debounce FSM; emits one registered pulse per accepted press.
module sseg_rot_db #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_press
);

   localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DB_HI = 2'd1,
      S_HELD  = 2'd2,
      S_DB_LO = 2'd3
   } db_state_t;

   logic             r_s1;
   logic             r_s2;
   db_state_t        r_state;
   db_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_press;
   logic             w_press;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_press <= w_press;
      end
   end

   // The press pulse fires only on the DB_HI -> HELD transition, so holds never repeat.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_press     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_s2) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_DB_HI;
            end
         end
         S_DB_HI: begin
            if (!r_s2) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_HELD;
               w_press     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_HELD: begin
            if (!r_s2) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_DB_LO;
            end
         end
         S_DB_LO: begin
            if (r_s2) begin
               w_state_nxt = S_HELD;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_press = r_press;

endmodule

module sseg_rot_ctrl #(
   parameter int unsigned DB_CYCLES = 1_000_000,
   parameter int unsigned STEP_LEN  = 33_554_432
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_run,
   input  logic       btn_speed,
`ifdef SSEG_STEP_EN
   input  logic       btn_step,
`endif
   output logic       en,
   output logic       running,
   output logic [1:0] speed
);

   if (DB_CYCLES < 2) begin : g_bad_db
      $error("sseg_rot_ctrl: DB_CYCLES must be at least 2");
   end
   if (STEP_LEN < 1) begin : g_bad_step
      $error("sseg_rot_ctrl: STEP_LEN must be at least 1");
   end

   logic       w_run_press;
   logic       w_speed_press;
   logic       r_running;
   logic [1:0] r_speed;
   logic [2:0] r_presc;
   logic [2:0] w_mask;
   logic       w_tick;

   sseg_rot_db #(.DB_CYCLES(DB_CYCLES)) u_db_run (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (btn_run),
      .o_press (w_run_press)
   );

   sseg_rot_db #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (btn_speed),
      .o_press (w_speed_press)
   );

   // Any accepted press restarts the prescaler so the first strobe lands immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_running <= 1'b0;
         r_speed   <= 2'd0;
         r_presc   <= 3'd0;
      end else begin
         if (w_run_press) begin
            r_running <= ~r_running;
         end
         if (w_speed_press) begin
            r_speed <= r_speed + 2'd1;
         end
         if (w_run_press || w_speed_press) begin
            r_presc <= 3'd0;
         end else if (r_running) begin
            r_presc <= r_presc + 3'd1;
         end
      end
   end

   always_comb begin
      w_mask = 3'b000;
      case (r_speed)
         2'd0:    w_mask = 3'b000;
         2'd1:    w_mask = 3'b001;
         2'd2:    w_mask = 3'b011;
         default: w_mask = 3'b111;
      endcase
   end

   assign w_tick = ((r_presc & w_mask) == 3'd0);

`ifdef SSEG_STEP_EN
   localparam int unsigned STEP_W = $clog2(STEP_LEN + 1);

   logic              w_step_press;
   logic [STEP_W-1:0] r_step_cnt;
   logic              w_stepping;

   sseg_rot_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (btn_step),
      .o_press (w_step_press)
   );

   assign w_stepping = (r_step_cnt != '0);

   // A run press cancels any step in flight; step presses only load from an idle pause.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_step_cnt <= '0;
      end else if (w_run_press) begin
         r_step_cnt <= '0;
      end else if (w_step_press && !r_running && !w_stepping) begin
         r_step_cnt <= STEP_W'(STEP_LEN);
      end else if (w_stepping) begin
         r_step_cnt <= r_step_cnt - STEP_W'(1);
      end
   end

   assign en = r_running ? w_tick : w_stepping;
`else
   assign en = r_running & w_tick;
`endif

   assign running = r_running;
   assign speed   = r_speed;

endmodule

// File: tb/tb_sseg_rot_ctrl.sv
// Scoreboard bench for sseg_rot_ctrl with DB_CYCLES=4, STEP_LEN=8.
// Step-button scenarios run only when SSEG_STEP_EN is defined.
module tb_sseg_rot_ctrl;

   localparam int unsigned DB = 4;
   localparam int unsigned SL = 8;

   typedef struct {
      int         at;
      logic       run;
      logic [1:0] spd;
      logic       en;
      logic       chk_en;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       btn_run;
   logic       btn_speed;
`ifdef SSEG_STEP_EN
   logic       btn_step;
`endif
   logic       en;
   logic       running;
   logic [1:0] speed;

   exp_t  q[$];
   string nq[$];
   int    cyc;
   int    nvec;
   int    nmis;
   exp_t  m_x;
   string m_nm;

   sseg_rot_ctrl #(.DB_CYCLES(DB), .STEP_LEN(SL)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_run   (btn_run),
      .btn_speed (btn_speed),
`ifdef SSEG_STEP_EN
      .btn_step  (btn_step),
`endif
      .en        (en),
      .running   (running),
      .speed     (speed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Queue an expectation for the cycle `dly` posedges from now.
   task automatic expect_at(input int dly, input logic r, input logic [1:0] s,
                            input logic e, input logic ce, input string nm);
      exp_t x;
      x.at     = cyc + dly;
      x.run    = r;
      x.spd    = s;
      x.en     = e;
      x.chk_en = ce;
      q.push_back(x);
      nq.push_back(nm);
   endtask

   // Monitor: compare on the falling edge whenever an expectation is due.
   initial begin
      nvec = 0;
      nmis = 0;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].at <= cyc) begin
            m_x  = q.pop_front();
            m_nm = nq.pop_front();
            nvec = nvec + 1;
            if (m_x.at != cyc) begin
               nmis = nmis + 1;
               $display("FAIL %s: check for cycle %0d reached at cycle %0d", m_nm, m_x.at, cyc);
            end else if (running !== m_x.run || speed !== m_x.spd ||
                         (m_x.chk_en && en !== m_x.en)) begin
               nmis = nmis + 1;
               $display("FAIL %s @%0d: got running=%b speed=%0d en=%b, want running=%b speed=%0d en=%b%s",
                        m_nm, cyc, running, speed, en, m_x.run, m_x.spd, m_x.en,
                        m_x.chk_en ? "" : " (en not checked)");
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      btn_run   = 1'b0;
      btn_speed = 1'b0;
`ifdef SSEG_STEP_EN
      btn_step  = 1'b0;
`endif
      repeat (3) tick();
      expect_at(0, 1'b0, 2'd0, 1'b0, 1'b1, "reset_hold");
      reset = 1'b0;
      expect_at(3, 1'b0, 2'd0, 1'b0, 1'b1, "idle_no_btn");
      repeat (5) tick();

      // Long hold: one toggle, visible 7 cycles after the input edge.
      btn_run = 1'b1;
      expect_at(7, 1'b0, 2'd0, 1'b0, 1'b1, "run_pre");
      for (int j = 8; j < 13; j++) expect_at(j, 1'b1, 2'd0, 1'b1, 1'b1, "run_on");
      repeat (10) tick();
      btn_run = 1'b0;
      expect_at(10, 1'b1, 2'd0, 1'b1, 1'b1, "run_hold_once");
      repeat (14) tick();

      // Short glitches must be rejected.
      btn_run = 1'b1;
      repeat (2) tick();
      btn_run = 1'b0;
      repeat (8) tick();
      btn_run = 1'b1;
      repeat (3) tick();
      btn_run = 1'b0;
      repeat (10) tick();
      expect_at(0, 1'b1, 2'd0, 1'b1, 1'b1, "glitch_rejected");

      // Speed presses while running: periods 2, 4, 8, then continuous.
      for (int s = 1; s <= 4; s++) begin
         btn_speed = 1'b1;
         expect_at(7, 1'b1, 2'(s - 1), 1'b0, 1'b0, "speed_pre");
         for (int j = 0; j < 16; j++)
            expect_at(8 + j, 1'b1, 2'(s), ((j % (1 << (s % 4))) == 0), 1'b1, "speed_en");
         repeat (6) tick();
         btn_speed = 1'b0;
         repeat (18) tick();
      end

      // Asynchronous reset in the middle of a debounce.
      btn_speed = 1'b1;
      repeat (4) tick();
      reset     = 1'b1;
      btn_speed = 1'b0;
      expect_at(0, 1'b0, 2'd0, 1'b0, 1'b1, "async_reset");
      repeat (2) tick();
      expect_at(0, 1'b0, 2'd0, 1'b0, 1'b1, "reset_held");
      reset = 1'b0;
      for (int j = 1; j < 13; j++) expect_at(j, 1'b0, 2'd0, 1'b0, 1'b1, "quiet_after_reset");
      repeat (14) tick();

      // Run and speed pressed together from reset.
      btn_run   = 1'b1;
      btn_speed = 1'b1;
      expect_at(7, 1'b0, 2'd0, 1'b0, 1'b1, "both_pre");
      for (int j = 0; j < 8; j++)
         expect_at(8 + j, 1'b1, 2'd1, ((j % 2) == 0), 1'b1, "both_en");
      repeat (6) tick();
      btn_run   = 1'b0;
      btn_speed = 1'b0;
      repeat (18) tick();

`ifdef SSEG_STEP_EN
      // Pause.
      btn_run = 1'b1;
      expect_at(7, 1'b1, 2'd1, 1'b0, 1'b0, "pause_pre");
      for (int j = 8; j < 13; j++) expect_at(j, 1'b0, 2'd1, 1'b0, 1'b1, "paused");
      repeat (6) tick();
      btn_run = 1'b0;
      repeat (18) tick();

      // Step of exactly 8 cycles; a speed press mid-step does not disturb it.
      btn_step = 1'b1;
      expect_at(7, 1'b0, 2'd1, 1'b0, 1'b1, "step_pre");
      expect_at(8, 1'b0, 2'd1, 1'b1, 1'b1, "step_en");
      expect_at(9, 1'b0, 2'd1, 1'b1, 1'b1, "step_en");
      for (int j = 10; j < 16; j++) expect_at(j, 1'b0, 2'd2, 1'b1, 1'b1, "step_en_spd");
      for (int j = 16; j < 21; j++) expect_at(j, 1'b0, 2'd2, 1'b0, 1'b1, "step_done");
      repeat (2) tick();
      btn_speed = 1'b1;
      repeat (3) tick();
      btn_step = 1'b0;
      repeat (3) tick();
      btn_speed = 1'b0;
      repeat (16) tick();

      // Run press mid-step cancels the step and resumes prescaled en.
      btn_step = 1'b1;
      expect_at(7, 1'b0, 2'd2, 1'b0, 1'b1, "step2_pre");
      for (int j = 8; j < 11; j++) expect_at(j, 1'b0, 2'd2, 1'b1, 1'b1, "step2_en");
      for (int j = 11; j < 23; j++)
         expect_at(j, 1'b1, 2'd2, (((j - 11) % 4) == 0), 1'b1, "resume_en");
      repeat (3) tick();
      btn_run = 1'b1;
      repeat (2) tick();
      btn_step = 1'b0;
      repeat (4) tick();
      btn_run = 1'b0;
      repeat (15) tick();
`endif

      for (int i = 0; i < 100 && q.size() != 0; i++) tick();
      if (q.size() != 0) begin
         nvec = nvec + 1;
         nmis = nmis + 1;
         $display("FAIL drain: %0d checks still pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
